// File: rtl/uart_pkg.sv
// Shared types and constants for the configurable UART receiver.
package uart_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_PUSH,
        S_WAIT_HIGH
    } rxState_t;

    localparam int unsigned PARITY_NONE = 0;
    localparam int unsigned PARITY_ODD  = 1;
    localparam int unsigned PARITY_EVEN = 2;

    // System clocks per serial bit; a short fixed value keeps fast simulation builds quick.
    function automatic int unsigned delayFrames(input int unsigned fmaxMHz,
                                                input int unsigned baudRate);
`ifdef FAST_UART
        return 32'd4;
`else
        return (fmaxMHz * 32'd1000000) / baudRate;
`endif
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Show-ahead receive FIFO with wrap-bit pointers and a drop-on-full overrun pulse.
module uart_rx_fifo #(
    parameter int unsigned WIDTH = 11,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wrEn,
    input  logic [WIDTH-1:0] wrData,
    input  logic             rdReady,
    output logic [WIDTH-1:0] rdData,
    output logic             rdValid,
    output logic             overrun
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wrPtr;
    logic [PW-1:0]    rdPtr;
    logic             full_c;
    logic             pop_c;
    logic             push_c;

    assign rdValid = (wrPtr != rdPtr);
    assign full_c  = (wrPtr[AW] != rdPtr[AW]) && (wrPtr[AW-1:0] == rdPtr[AW-1:0]);
    assign pop_c   = rdValid && rdReady;
    // A pop in the same cycle frees the head slot, so a full FIFO can still take the write.
    assign push_c  = wrEn && (!full_c || pop_c);
    assign rdData  = mem[rdPtr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrPtr   <= '0;
            rdPtr   <= '0;
            overrun <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push_c) begin
                mem[wrPtr[AW-1:0]] <= wrData;
                wrPtr              <= wrPtr + PW'(1);
            end
            if (pop_c) begin
                rdPtr <= rdPtr + PW'(1);
            end
            overrun <= wrEn && full_c && !pop_c;
        end
    end

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: mid-bit sampling FSM feeding a show-ahead FIFO with per-frame error flags.
module uart_rx_cfg
    import uart_pkg::*;
#(
    parameter int unsigned FMAX_MHz   = 27,
    parameter int unsigned BaudRate   = 115200,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned PARITY     = 0,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 uart_rx,
    output logic [DATA_BITS-1:0] rdata,
    output logic                 rvalid,
    input  logic                 rready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 break_det,
    output logic                 overrun
);
    localparam int unsigned DELAY_FRAMES = delayFrames(FMAX_MHz, BaudRate);
    localparam int unsigned HALF         = DELAY_FRAMES / 2;
    localparam int unsigned FIFO_W       = DATA_BITS + 3;

    logic rxMeta;
    logic rxSync;

    // Two-flop synchroniser, idles high so reset does not look like a start bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rxMeta <= 1'b1;
            rxSync <= 1'b1;
        end else begin
            rxMeta <= uart_rx;
            rxSync <= rxMeta;
        end
    end

    rxState_t             state, stateNext;
    logic [31:0]          baudCnt, baudCntNext;
    logic [3:0]           bitCnt, bitCntNext;
    logic [DATA_BITS-1:0] shiftReg, shiftRegNext;
    logic                 parBit, parBitNext;
    logic                 frameErr, frameErrNext;
    logic                 stopLow, stopLowNext;
    logic                 pushEn_c;
    logic                 bitTick_c;
    logic                 dataXor_c;
    logic                 parityErr_c;
    logic                 breakDet_c;

    assign bitTick_c = (baudCnt == 32'(DELAY_FRAMES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            baudCnt  <= '0;
            bitCnt   <= '0;
            shiftReg <= '0;
            parBit   <= 1'b0;
            frameErr <= 1'b0;
            stopLow  <= 1'b0;
        end else begin
            state    <= stateNext;
            baudCnt  <= baudCntNext;
            bitCnt   <= bitCntNext;
            shiftReg <= shiftRegNext;
            parBit   <= parBitNext;
            frameErr <= frameErrNext;
            stopLow  <= stopLowNext;
        end
    end

    always_comb begin
        stateNext    = state;
        baudCntNext  = baudCnt + 32'd1;
        bitCntNext   = bitCnt;
        shiftRegNext = shiftReg;
        parBitNext   = parBit;
        frameErrNext = frameErr;
        stopLowNext  = stopLow;
        pushEn_c     = 1'b0;

        case (state)
            S_IDLE: begin
                baudCntNext = '0;
                if (!rxSync) begin
                    stateNext    = S_START;
                    bitCntNext   = '0;
                    parBitNext   = 1'b0;
                    frameErrNext = 1'b0;
                    stopLowNext  = 1'b0;
                end
            end
            S_START: begin
                if (baudCnt == 32'(HALF - 1)) begin
                    baudCntNext = '0;
                    stateNext   = rxSync ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (bitTick_c) begin
                    baudCntNext  = '0;
                    shiftRegNext = {rxSync, shiftReg[DATA_BITS-1:1]};
                    bitCntNext   = bitCnt + 4'd1;
                    if (bitCnt == 4'(DATA_BITS - 1)) begin
                        bitCntNext = '0;
                        stateNext  = (PARITY != PARITY_NONE) ? S_PARITY : S_STOP;
                    end
                end
            end
            S_PARITY: begin
                if (bitTick_c) begin
                    baudCntNext = '0;
                    parBitNext  = rxSync;
                    stateNext   = S_STOP;
                end
            end
            S_STOP: begin
                if (bitTick_c) begin
                    baudCntNext = '0;
                    bitCntNext  = bitCnt + 4'd1;
                    if (!rxSync) begin
                        frameErrNext = 1'b1;
                    end
                    if (bitCnt == 4'd0) begin
                        stopLowNext = !rxSync;
                    end
                    if (bitCnt == 4'(STOP_BITS - 1)) begin
                        stateNext = S_PUSH;
                    end
                end
            end
            S_PUSH: begin
                pushEn_c    = 1'b1;
                baudCntNext = '0;
                stateNext   = frameErr ? S_WAIT_HIGH : S_IDLE;
            end
            S_WAIT_HIGH: begin
                baudCntNext = '0;
                if (rxSync) begin
                    stateNext = S_IDLE;
                end
            end
            default: begin
                stateNext = S_IDLE;
            end
        endcase
    end

    // parBit stays 0 when parity is disabled, so it never masks a break in that mode.
    assign dataXor_c   = (^shiftReg) ^ parBit;
    assign parityErr_c = (PARITY == PARITY_ODD)  ? !dataXor_c :
                         (PARITY == PARITY_EVEN) ?  dataXor_c : 1'b0;
    assign breakDet_c  = (shiftReg == '0) && !parBit && stopLow;

    logic [FIFO_W-1:0] fifoIn;
    logic [FIFO_W-1:0] fifoOut;

    assign fifoIn = {shiftReg, parityErr_c, frameErr, breakDet_c};

    uart_rx_fifo #(
        .WIDTH(FIFO_W),
        .DEPTH(FIFO_DEPTH)
    ) fifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .wrEn   (pushEn_c),
        .wrData (fifoIn),
        .rdReady(rready),
        .rdData (fifoOut),
        .rdValid(rvalid),
        .overrun(overrun)
    );

    assign {rdata, parity_err, frame_err, break_det} = fifoOut;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed bench for uart_rx_cfg: 8N1 instance and an even-parity instance at 16 clocks per bit.
`timescale 1ns/1ps
module tb_uart_rx_cfg;
    import uart_pkg::*;

    localparam int unsigned BIT_CLKS = 16;
    localparam int unsigned HALF     = 8;

    logic       clk     = 1'b0;
    logic       rst_n   = 1'b0;
    logic       rxA     = 1'b1;
    logic       rxB     = 1'b1;
    logic       rreadyA = 1'b0;
    logic       rreadyB = 1'b0;
    logic [7:0] rdataA, rdataB;
    logic       rvalidA, peA, feA, bdA, ovA;
    logic       rvalidB, peB, feB, bdB, ovB;

    int nVec   = 0;
    int nFail  = 0;
    int rvCntA = 0;
    int ovCntA = 0;
    int ovCntB = 0;
    logic [10:0] qA[$];
    logic [10:0] qB[$];

    always #5 clk = ~clk;

    uart_rx_cfg #(
        .FMAX_MHz(1), .BaudRate(62500), .DATA_BITS(8),
        .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)
    ) dutA (
        .clk(clk), .rst_n(rst_n), .uart_rx(rxA), .rdata(rdataA), .rvalid(rvalidA),
        .rready(rreadyA), .parity_err(peA), .frame_err(feA), .break_det(bdA), .overrun(ovA)
    );

    uart_rx_cfg #(
        .FMAX_MHz(1), .BaudRate(62500), .DATA_BITS(8),
        .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)
    ) dutB (
        .clk(clk), .rst_n(rst_n), .uart_rx(rxB), .rdata(rdataB), .rvalid(rvalidB),
        .rready(rreadyB), .parity_err(peB), .frame_err(feB), .break_det(bdB), .overrun(ovB)
    );

    // Record every accepted entry as {data, parity_err, frame_err, break_det}.
    always @(negedge clk) begin
        if (rvalidA) rvCntA++;
        if (rvalidA && rreadyA) qA.push_back({rdataA, peA, feA, bdA});
        if (ovA) ovCntA++;
        if (rvalidB && rreadyB) qB.push_back({rdataB, peB, feB, bdB});
        if (ovB) ovCntB++;
    end

    task automatic waitClk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic sendA(input logic [7:0] d);
        logic [31:0] bits;
        bits = 32'({1'b1, d, 1'b0});
        for (int i = 0; i < 10; i++) begin
            rxA = bits[i];
            waitClk(BIT_CLKS);
        end
    endtask

    task automatic sendB(input logic [7:0] d, input logic par);
        logic [31:0] bits;
        bits = 32'({1'b1, par, d, 1'b0});
        for (int i = 0; i < 11; i++) begin
            rxB = bits[i];
            waitClk(BIT_CLKS);
        end
    endtask

    task automatic test_reset();
        waitClk(3);
        nVec++; if (rvalidA !== 1'b0) begin nFail++; $display("FAIL reset_rvalid: got %b want 0", rvalidA); end
        nVec++; if (rdataA !== 8'h00) begin nFail++; $display("FAIL reset_rdata: got %h want 00", rdataA); end
        nVec++; if ({peA, feA, bdA, ovA} !== 4'b0000) begin nFail++; $display("FAIL reset_flags: got %b want 0000", {peA, feA, bdA, ovA}); end
        nVec++; if (rvalidB !== 1'b0) begin nFail++; $display("FAIL reset_rvalidB: got %b want 0", rvalidB); end
        rst_n = 1'b1;
        waitClk(4);
        nVec++; if ({rvalidA, rdataA, peA, feA, bdA, ovA} !== 13'd0) begin nFail++; $display("FAIL post_reset_outputs: got %h want 0", {rvalidA, rdataA, peA, feA, bdA, ovA}); end
        nVec++; if (dutA.state !== S_IDLE) begin nFail++; $display("FAIL post_reset_state: got %0d want %0d", dutA.state, S_IDLE); end
    endtask

    task automatic test_basic();
        logic [7:0]  pats [4];
        logic [10:0] got;
        pats = '{8'hA5, 8'h3C, 8'hFF, 8'h80};
        rreadyA = 1'b1;
        for (int k = 0; k < 4; k++) begin
            qA.delete();
            rvCntA = 0;
            sendA(pats[k]);
            waitClk(2 * BIT_CLKS);
            got = (qA.size() > 0) ? qA[0] : 'x;
            nVec++; if (qA.size() !== 1) begin nFail++; $display("FAIL basic_count[%h]: got %0d want 1", pats[k], qA.size()); end
            nVec++; if (got !== {pats[k], 3'b000}) begin nFail++; $display("FAIL basic_entry[%h]: got %h want %h", pats[k], got, {pats[k], 3'b000}); end
            nVec++; if (rvCntA !== 1) begin nFail++; $display("FAIL basic_rvalid_cycles[%h]: got %0d want 1", pats[k], rvCntA); end
        end
    endtask

    task automatic test_latency();
        int budget;
        rreadyA = 1'b0;
        qA.delete();
        fork
            sendA(8'h5A);
        join_none
        budget = 0;
        while (dutA.state !== S_PUSH && budget < 400) begin
            waitClk(1);
            budget++;
        end
        nVec++; if (budget >= 400) begin nFail++; $display("FAIL latency_push_seen: got timeout want PUSH"); end
        nVec++; if (rvalidA !== 1'b0) begin nFail++; $display("FAIL latency_in_push: got %b want 0", rvalidA); end
        waitClk(1);
        nVec++; if (rvalidA !== 1'b1) begin nFail++; $display("FAIL latency_after_push: got %b want 1", rvalidA); end
        nVec++; if (rdataA !== 8'h5A) begin nFail++; $display("FAIL latency_head: got %h want 5a", rdataA); end
        waitClk(2 * BIT_CLKS);
        rreadyA = 1'b1;
        waitClk(4);
        nVec++; if (rvalidA !== 1'b0) begin nFail++; $display("FAIL latency_drained: got %b want 0", rvalidA); end
    endtask

    task automatic test_parity();
        logic [7:0]  d   [4];
        logic        par [4];
        logic        pe  [4];
        logic [10:0] got;
        d   = '{8'h03, 8'h03, 8'h07, 8'h07};
        par = '{1'b1,  1'b0,  1'b1,  1'b0};
        pe  = '{1'b1,  1'b0,  1'b0,  1'b1};
        rreadyB = 1'b1;
        ovCntB  = 0;
        for (int k = 0; k < 4; k++) begin
            qB.delete();
            sendB(d[k], par[k]);
            waitClk(2 * BIT_CLKS);
            got = (qB.size() > 0) ? qB[0] : 'x;
            nVec++; if (qB.size() !== 1) begin nFail++; $display("FAIL parity_count[%0d]: got %0d want 1", k, qB.size()); end
            nVec++; if (got !== {d[k], pe[k], 2'b00}) begin nFail++; $display("FAIL parity_entry[%0d]: got %h want %h", k, got, {d[k], pe[k], 2'b00}); end
        end
        nVec++; if (ovCntB !== 0) begin nFail++; $display("FAIL parity_overrun: got %0d want 0", ovCntB); end
    endtask

    task automatic test_break();
        logic [10:0] got;
        rreadyA = 1'b1;
        qA.delete();
        rxA = 1'b0;
        waitClk(20 * BIT_CLKS);
        got = (qA.size() > 0) ? qA[0] : 'x;
        nVec++; if (qA.size() !== 1) begin nFail++; $display("FAIL break_count_low: got %0d want 1", qA.size()); end
        nVec++; if (got !== {8'h00, 3'b011}) begin nFail++; $display("FAIL break_entry: got %h want %h", got, {8'h00, 3'b011}); end
        nVec++; if (dutA.state !== S_WAIT_HIGH) begin nFail++; $display("FAIL break_wait_state: got %0d want %0d", dutA.state, S_WAIT_HIGH); end
        rxA = 1'b1;
        waitClk(3 * BIT_CLKS);
        nVec++; if (qA.size() !== 1) begin nFail++; $display("FAIL break_count_high: got %0d want 1", qA.size()); end
        nVec++; if (dutA.state !== S_IDLE) begin nFail++; $display("FAIL break_idle_state: got %0d want %0d", dutA.state, S_IDLE); end
    endtask

    task automatic test_glitch();
        qA.delete();
        rxA = 1'b0;
        waitClk(HALF - 2);
        rxA = 1'b1;
        waitClk(3 * BIT_CLKS);
        nVec++; if (qA.size() !== 0) begin nFail++; $display("FAIL glitch_count: got %0d want 0", qA.size()); end
        nVec++; if (rvalidA !== 1'b0) begin nFail++; $display("FAIL glitch_rvalid: got %b want 0", rvalidA); end
        nVec++; if (dutA.state !== S_IDLE) begin nFail++; $display("FAIL glitch_state: got %0d want %0d", dutA.state, S_IDLE); end
    endtask

    task automatic test_overrun();
        rreadyA = 1'b0;
        qA.delete();
        ovCntA = 0;
        for (int k = 1; k <= 5; k++) begin
            sendA(8'(k));
        end
        waitClk(2 * BIT_CLKS);
        nVec++; if (ovCntA !== 1) begin nFail++; $display("FAIL overrun_pulses: got %0d want 1", ovCntA); end
        nVec++; if (rvalidA !== 1'b1 || rdataA !== 8'h01) begin nFail++; $display("FAIL overrun_head: got %b/%h want 1/01", rvalidA, rdataA); end
        rreadyA = 1'b1;
        waitClk(10);
        nVec++; if (qA.size() !== 4) begin nFail++; $display("FAIL overrun_drain_count: got %0d want 4", qA.size()); end
        for (int k = 0; k < 4; k++) begin
            logic [10:0] got;
            got = (qA.size() > k) ? qA[k] : 'x;
            nVec++; if (got !== {8'(k + 1), 3'b000}) begin nFail++; $display("FAIL overrun_drain[%0d]: got %h want %h", k, got, {8'(k + 1), 3'b000}); end
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] bits;
        logic [10:0] got;
        rreadyA = 1'b1;
        qA.delete();
        bits = 32'({1'b1, 8'h55, 1'b0});
        for (int i = 0; i < 5; i++) begin
            rxA = bits[i];
            waitClk(BIT_CLKS);
        end
        rxA = bits[5];
        waitClk(BIT_CLKS / 2);
        rst_n = 1'b0;
        #1;
        nVec++; if (dutA.state !== S_IDLE) begin nFail++; $display("FAIL midreset_state: got %0d want %0d", dutA.state, S_IDLE); end
        rxA = 1'b1;
        waitClk(6 * BIT_CLKS);
        rst_n = 1'b1;
        waitClk(BIT_CLKS);
        sendA(8'h3C);
        waitClk(2 * BIT_CLKS);
        got = (qA.size() > 0) ? qA[0] : 'x;
        nVec++; if (qA.size() !== 1) begin nFail++; $display("FAIL midreset_count: got %0d want 1", qA.size()); end
        nVec++; if (got !== {8'h3C, 3'b000}) begin nFail++; $display("FAIL midreset_entry: got %h want %h", got, {8'h3C, 3'b000}); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_latency();
        test_parity();
        test_break();
        test_glitch();
        test_overrun();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
        $finish;
    end

endmodule
